// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_sequencer: walks a synchronous note ROM, holding each note for its     |
// | programmed beat count. Define NOTE_SEQUENCER_LOOP_EN to loop the song.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module note_sequencer #(
  parameter int ADDR_W = 7,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      beat,
  input  logic                      play,
  input  logic                      stop,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note_out,
  output logic                      note_active,
  output logic                      new_note,
  output logic                      song_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_PLAY   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]   note_out_q, note_out_d;
  logic [DUR_W-1:0]    remaining_q, remaining_d;
  logic                new_note_q, new_note_d;
  logic                song_done_q, song_done_d;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                beat_counted;

  assign rom_note     = rom_data[NOTE_W+DUR_W-1 -: NOTE_W];
  assign rom_dur      = rom_data[DUR_W-1:0];
  assign beat_counted = beat && play;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    note_out_d  = note_out_q;
    remaining_d = remaining_q;
    new_note_d  = 1'b0;
`ifdef NOTE_SEQUENCER_LOOP_EN
    song_done_d = 1'b0;
`else
    song_done_d = song_done_q;
`endif

    if (stop) begin
      state_d     = S_IDLE;
      rom_addr_d  = '0;
      note_out_d  = '0;
      remaining_d = '0;
      song_done_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rom_addr_d = '0;
          if (play) state_d = S_FETCH;
        end
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          if (rom_dur != '0) begin
            note_out_d  = rom_note;
            remaining_d = rom_dur;
            new_note_d  = 1'b1;
            state_d     = S_PLAY;
          end else begin
            song_done_d = 1'b1;
`ifdef NOTE_SEQUENCER_LOOP_EN
            rom_addr_d  = '0;
            state_d     = S_FETCH;
`else
            state_d     = S_DONE;
`endif
          end
        end
        S_PLAY: begin
          if (beat_counted) begin
            // The <= guard keeps remaining from wrapping even if it were ever 0.
            if (remaining_q <= DUR_ONE) begin
              remaining_d = '0;
              if (rom_addr_q == LAST_ADDR) begin
                song_done_d = 1'b1;
`ifdef NOTE_SEQUENCER_LOOP_EN
                rom_addr_d  = '0;
                state_d     = S_FETCH;
`else
                state_d     = S_DONE;
`endif
              end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = S_FETCH;
              end
            end else begin
              remaining_d = remaining_q - DUR_ONE;
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: begin
          state_d    = S_IDLE;
          rom_addr_d = '0;
          note_out_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      note_out_q  <= '0;
      remaining_q <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      note_out_q  <= note_out_d;
      remaining_q <= remaining_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign note_out    = note_out_q;
  assign new_note    = new_note_q;
  assign song_done   = song_done_q;
  // A paused note goes silent immediately, so play is used directly here.
  assign note_active = (state_q == S_PLAY) && play && (note_out_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_note_sequencer: randomized and directed stimulus, cycle scoreboard.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_note_sequencer;

  localparam int ADDR_W = 7;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     beat = 1'b0;
  logic                     play = 1'b0;
  logic                     stop = 1'b0;
  logic [ADDR_W-1:0]        rom_addr;
  logic [NOTE_W+DUR_W-1:0]  rom_data = '0;
  logic [NOTE_W-1:0]        note_out;
  logic                     note_active;
  logic                     new_note;
  logic                     song_done;

  logic [NOTE_W+DUR_W-1:0]  rom_mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  note_sequencer #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .beat(beat), .play(play), .stop(stop),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_out(note_out),
    .note_active(note_active), .new_note(new_note), .song_done(song_done)
  );

  // Reference model: song position, beats left, and a fetch countdown.
  int m_idx = 0, m_rem = 0, m_note = 0, m_fetch = 0;
  bit m_idle = 1, m_playing = 0, m_done = 0, m_new = 0;

  task automatic song_end();
    m_done = 1;
`ifdef NOTE_SEQUENCER_LOOP_EN
    m_idx   = 0;
    m_fetch = 2;
`endif
  endtask

  task automatic model_edge();
    logic [NOTE_W+DUR_W-1:0] ent;
    m_new = 0;
    if (reset || stop) begin
      m_idx = 0; m_rem = 0; m_note = 0; m_fetch = 0;
      m_idle = 1; m_playing = 0; m_done = 0;
    end else begin
`ifdef NOTE_SEQUENCER_LOOP_EN
      m_done = 0;
`endif
      if (m_idle) begin
        if (play) begin m_idle = 0; m_fetch = 2; end
      end else if (m_fetch == 2) begin
        m_fetch = 1;
      end else if (m_fetch == 1) begin
        m_fetch = 0;
        ent = rom_mem[m_idx];
        if (ent[DUR_W-1:0] != 0) begin
          m_note = int'(ent[NOTE_W+DUR_W-1:DUR_W]);
          m_rem  = int'(ent[DUR_W-1:0]);
          m_playing = 1;
          m_new = 1;
        end else begin
          song_end();
        end
      end else if (m_playing && beat && play) begin
        m_rem--;
        if (m_rem == 0) begin
          m_playing = 0;
          if (m_idx == DEPTH - 1) song_end();
          else begin m_idx++; m_fetch = 2; end
        end
      end
    end
  endtask

  // One clock: advance the model over the edge, drive new inputs, queue expectation.
  task automatic step(input logic r, input logic b, input logic p, input logic s);
    logic act;
    @(posedge clk);
    #2;
    model_edge();
    reset = r; beat = b; play = p; stop = s;
    act = m_playing && p && (m_note != 0);
    exp_q.push_back({7'(m_idx), 6'(m_note), act, m_new, m_done});
  endtask

  int beat_cnt = 0, per_min = 3, per_max = 3;

  task automatic gen_beat(output logic b);
    if (beat_cnt == 0) begin
      b = 1'b1;
      beat_cnt = $urandom_range(per_max, per_min);
    end else begin
      b = 1'b0;
      beat_cnt--;
    end
  endtask

  task automatic run(input int n, input logic p);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_beat(b);
      step(1'b0, b, p, 1'b0);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    beat_cnt = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = '0;
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares all outputs.
  initial begin
    logic [15:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {rom_addr, note_out, note_active, new_note, song_done};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL outputs t=%0t: got addr=%0d note=%0d act=%b new=%b done=%b, expected addr=%0d note=%0d act=%b new=%b done=%b",
                   $time, a[15:9], a[8:3], a[2], a[1], a[0], e[15:9], e[8:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic b;
    clear_rom();

    // Basic song: {5,2} {9,1} end, play from cycle 10, beat every 8 cycles.
    rom_mem[0] = {6'd5, 6'd2};
    rom_mem[1] = {6'd9, 6'd1};
    per_min = 7; per_max = 7;
    do_reset();
    run(7, 1'b0);
    run(60, 1'b1);
`ifndef NOTE_SEQUENCER_LOOP_EN
    check_val("basic_done", int'(song_done), 1);
    check_val("basic_addr", int'(rom_addr), 2);
    check_val("basic_note", int'(note_out), 9);
`endif

    // Pause mid-note of duration 4.
    clear_rom();
    rom_mem[0] = {6'd7, 6'd4};
    rom_mem[1] = {6'd3, 6'd2};
    do_reset();
    run(15, 1'b1);
    run(26, 1'b0);
    run(60, 1'b1);

    // Rest entry followed by a note.
    clear_rom();
    rom_mem[0] = {6'd0, 6'd3};
    rom_mem[1] = {6'd12, 6'd1};
    do_reset();
    run(50, 1'b1);

    // Stop coincident with a beat while playing, then replay.
    clear_rom();
    rom_mem[0] = {6'd21, 6'd5};
    rom_mem[1] = {6'd22, 6'd5};
    do_reset();
    run(12, 1'b1);
    for (int i = 0; i < 20; i++) begin
      gen_beat(b);
      step(1'b0, b, 1'b1, b);
      if (b) break;
    end
    run(1, 1'b1);
    check_val("stop_addr", int'(rom_addr), 0);
    check_val("stop_note", int'(note_out), 0);
    run(30, 1'b1);

    // Reset mid-play with beat high.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_note", int'(note_out), 0);
    check_val("rst_done", int'(song_done), 0);

    // Full ROM without an end marker.
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = {6'($urandom_range(63, 1)), 6'd1};
    per_min = 3; per_max = 3;
    do_reset();
    run(1100, 1'b1);
`ifndef NOTE_SEQUENCER_LOOP_EN
    check_val("full_addr", int'(rom_addr), DEPTH - 1);
    check_val("full_done", int'(song_done), 1);
`endif

    // Randomized songs, tempo, pauses, stops and resets.
    per_min = 3; per_max = 8;
    for (int song = 0; song < 12; song++) begin
      int len;
      clear_rom();
      len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++)
        rom_mem[i] = {6'($urandom_range(63, 0)), 6'($urandom_range(5, 1))};
      rom_mem[len] = {6'($urandom_range(63, 0)), 6'd0};
      do_reset();
      for (int c = 0; c < 400; c++) begin
        logic p, s;
        gen_beat(b);
        p = ($urandom_range(9, 0) != 0);
        s = ($urandom_range(149, 0) == 0);
        step(1'b0, b, p, s);
      end
    end

    run(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
